// File: rtl/conv_filter_5x5.sv
// 5x5 per-channel RGB888 convolution with a VSYNC-synchronised loadable kernel.
// Optional CONV_ROUND_EN macro: round half up before the normalising shift.
module conv_filter_5x5 #(
  parameter int unsigned SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pa,
  input  logic [23:0] pb,
  input  logic [23:0] pc,
  input  logic [23:0] pd,
  input  logic [23:0] pe,
  input  logic [2:0]  stat_in,
  input  logic        coef_we,
  input  logic [4:0]  coef_addr,
  input  logic [7:0]  coef_data,
  output logic [23:0] dout,
  output logic [2:0]  stat_o
);

  localparam int unsigned LAT    = 6;
  localparam int unsigned NTAP   = 25;
  localparam int unsigned CENTRE = 12;
  localparam int unsigned PW     = 17;
  localparam int unsigned SW     = 22;
  localparam logic signed [7:0] UNITY = 8'(2 ** SHIFT);
`ifdef CONV_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(2 ** (SHIFT - 1));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic [23:0]          rows_in [5];
  logic [7:0]           col_in  [5][3];
  logic [7:0]           col_q   [4][5][3];
  logic [7:0]           win     [5][5][3];
  logic signed [7:0]    shadow_q [NTAP];
  logic signed [7:0]    active_q [NTAP];
  logic                 vs_q;
  logic signed [PW-1:0] prod_c [5][5][3];
  logic signed [PW-1:0] prod_q [5][5][3];
  logic signed [SW-1:0] row_c  [5][3];
  logic signed [SW-1:0] row_q  [5][3];
  logic signed [SW-1:0] tot_c  [3];
  logic signed [SW-1:0] tot_q  [3];
  logic signed [SW-1:0] sh     [3];
  logic [23:0]          pix_c;
  logic [2:0]           stat_q [LAT];

  assign rows_in[0] = pa;
  assign rows_in[1] = pb;
  assign rows_in[2] = pc;
  assign rows_in[3] = pd;
  assign rows_in[4] = pe;
  assign stat_o     = stat_q[LAT-1];

  // Incoming column, zeroed outside active video for horizontal padding; ch 0 = R.
  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int ch = 0; ch < 3; ch++)
        col_in[r][ch] = stat_in[0] ? rows_in[r][8*(2-ch) +: 8] : 8'd0;
  end

  // Window: registered cols 0..3 plus the live column as col 4, so col 2 is two samples old.
  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int ch = 0; ch < 3; ch++) begin
        for (int c = 0; c < 4; c++) win[r][c][ch] = col_q[c][r][ch];
        win[r][4][ch] = col_in[r][ch];
      end
  end

  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        for (int ch = 0; ch < 3; ch++)
          prod_c[r][c][ch] = PW'($signed({1'b0, win[r][c][ch]})) * PW'(active_q[r*5+c]);
  end

  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int ch = 0; ch < 3; ch++) begin
        row_c[r][ch] = '0;
        for (int c = 0; c < 5; c++) row_c[r][ch] = row_c[r][ch] + SW'(prod_q[r][c][ch]);
      end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      tot_c[ch] = RND;
      for (int r = 0; r < 5; r++) tot_c[ch] = tot_c[ch] + SW'(row_q[r][ch]);
    end
  end

  // Normalise and clamp each channel to 0..255.
  always_comb begin
    pix_c = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sh[ch] = tot_q[ch] >>> SHIFT;
      if (sh[ch][SW-1])             pix_c[8*(2-ch) +: 8] = 8'd0;
      else if (sh[ch] > SW'(255))   pix_c[8*(2-ch) +: 8] = 8'hFF;
      else                          pix_c[8*(2-ch) +: 8] = sh[ch][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '{default: '0};
      prod_q <= '{default: '0};
      row_q  <= '{default: '0};
      tot_q  <= '{default: '0};
      stat_q <= '{default: '0};
      dout   <= '0;
      vs_q   <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= (i == CENTRE) ? UNITY : 8'sd0;
        active_q[i] <= (i == CENTRE) ? UNITY : 8'sd0;
      end
    end else begin
      for (int c = 0; c < 3; c++) col_q[c] <= col_q[c+1];
      col_q[3] <= col_in;
      prod_q   <= prod_c;
      row_q    <= row_c;
      tot_q    <= tot_c;
      stat_q[0] <= stat_in;
      for (int k = 1; k < LAT; k++) stat_q[k] <= stat_q[k-1];
      dout <= stat_q[LAT-2][0] ? pix_c : 24'd0;
      // Kernel swaps only on a VSYNC rise; a write in that cycle stays in shadow.
      vs_q <= stat_in[2];
      if (stat_in[2] && !vs_q) active_q <= shadow_q;
      if (coef_we && (coef_addr < 5'(NTAP))) shadow_q[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_conv_filter_5x5.sv
// Scoreboard bench for conv_filter_5x5: driver pushes expected pixels, monitor pops on stat_o[0].
module tb_conv_filter_5x5;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pa, pb, pc, pd, pe;
  logic [2:0]  stat_in;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [7:0]  coef_data;
  logic [23:0] dout;
  logic [2:0]  stat_o;

  logic [23:0] exp_q[$];
  logic [2:0]  stat_model [LAT];
  logic        started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  conv_filter_5x5 dut (
    .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
    .stat_in(stat_in), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .dout(dout), .stat_o(stat_o)
  );

  always #5 clk = ~clk;

  // Expected pixel: kind 0 = single centre tap c, kind 1 = all-ones box with cols valid columns.
  function automatic logic [23:0] exp_pix(input int kind, input int c, input logic [23:0] p,
                                          input int cols);
    logic [23:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int v, s, q;
      v = int'(p[8*ch +: 8]);
      s = (kind == 1) ? 5 * cols * v : v * c;
`ifdef CONV_ROUND_EN
      s = s + 8;
`endif
      q = s >>> 4;
      if (q < 0) q = 0;
      if (q > 255) q = 255;
      res[8*ch +: 8] = 8'(q);
    end
    return res;
  endfunction

  task automatic step(input logic [23:0] prow, input logic [23:0] pctr, input logic [2:0] st,
                      input logic r, input logic we, input logic [4:0] a, input logic [7:0] d,
                      input logic push, input logic [23:0] ev);
    pa = prow; pb = prow; pc = pctr; pd = prow; pe = prow;
    stat_in = st; rst = r; coef_we = we; coef_addr = a; coef_data = d;
    if (push && !r) exp_q.push_back(ev);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      for (int k = 0; k < LAT; k++) stat_model[k] = 3'b000;
    end else begin
      for (int k = LAT - 1; k > 0; k--) stat_model[k] = stat_model[k-1];
      stat_model[0] = st;
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++)
      step(24'h0, 24'h0, {1'b0, (j >= 2 && j < 5), 1'b0}, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 24'h0);
  endtask

  task automatic run_line(input logic [23:0] prow, input logic [23:0] pctr, input int len,
                          input int kind, input int c, input int rst_pos, input int we_pos,
                          input logic [4:0] wa, input logic [7:0] wd);
    for (int i = 0; i < len; i++) begin
      int cols, k, cc;
      cols = 0;
      for (int j = i - 2; j <= i + 2; j++) if (j >= 0 && j < len) cols++;
      k = kind; cc = c;
      if (rst_pos >= 0 && i > rst_pos) begin k = 0; cc = 16; end
      step(prow, pctr, 3'b001, (i == rst_pos), (i == we_pos), wa, wd, 1'b1,
           exp_pix(k, cc, pctr, cols));
    end
    idle(8);
  endtask

  task automatic set_kernel(input int kind, input int c);
    for (int i = 0; i < 25; i++)
      step(24'h0, 24'h0, 3'b000, 1'b0, 1'b1, 5'(i),
           (kind == 1) ? 8'd1 : ((i == 12) ? 8'(c) : 8'd0), 1'b0, 24'h0);
  endtask

  task automatic vsync_pulse(input logic we, input logic [4:0] a, input logic [7:0] d);
    step(24'h0, 24'h0, 3'b100, 1'b0, we, a, d, 1'b0, 24'h0);
    step(24'h0, 24'h0, 3'b100, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 24'h0);
    idle(2);
  endtask

  // Monitor: stat_o against the bench delay line; dout popped when valid, else must be zero.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checks++;
        if (stat_o !== stat_model[LAT-1]) begin
          errors++;
          $display("FAIL stat_o: got %b expected %b at %0t", stat_o, stat_model[LAT-1], $time);
        end
        checks++;
        if (stat_o[0] === 1'b1) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL dout_unexpected: got %h with no expected pixel at %0t", dout, $time);
          end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (dout !== e) begin
              errors++;
              $display("FAIL dout: got %h expected %h at %0t", dout, e, $time);
            end
          end
        end else if (dout !== 24'h0) begin
          errors++;
          $display("FAIL dout_blank: got %h expected 000000 at %0t", dout, $time);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < LAT; k++) stat_model[k] = 3'b000;
    for (int i = 0; i < 3; i++) step(24'h0, 24'h0, 3'b000, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 24'h0);
    idle(4);

    // Identity kernel after reset; distinct outer rows must not leak into the result.
    run_line(24'h010203, 24'h102030, 12, 0, 16, -1, -1, 5'd0, 8'd0);

    // Box kernel: edge columns see zero padding, interior gives 250>>4.
    set_kernel(1, 0);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h0A0A0A, 24'h0A0A0A, 12, 1, 0, -1, -1, 5'd0, 8'd0);

    // Saturation high and low.
    set_kernel(0, 127);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'hC8C8C8, 24'hC8C8C8, 8, 0, 127, -1, -1, 5'd0, 8'd0);
    set_kernel(0, -16);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'hC8C8C8, 24'hC8C8C8, 8, 0, -16, -1, -1, 5'd0, 8'd0);

    // Shadow timing: mid-line write waits for the VSYNC rise; addr 25 is ignored.
    set_kernel(0, 16);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h323232, 24'h323232, 10, 0, 16, -1, 4, 5'd12, 8'd32);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h323232, 24'h323232, 8, 0, 32, -1, -1, 5'd0, 8'd0);
    step(24'h0, 24'h0, 3'b000, 1'b0, 1'b1, 5'd25, 8'h7F, 1'b0, 24'h0);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h323232, 24'h323232, 8, 0, 32, -1, -1, 5'd0, 8'd0);
    // Write coincident with the VSYNC rise only lands on the following rise.
    vsync_pulse(1'b1, 5'd12, 8'd16);
    run_line(24'h323232, 24'h323232, 8, 0, 32, -1, -1, 5'd0, 8'd0);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h323232, 24'h323232, 8, 0, 16, -1, -1, 5'd0, 8'd0);

    // Mid-frame reset during a box-kernel line: flush, then identity output.
    set_kernel(1, 0);
    vsync_pulse(1'b0, 5'd0, 8'd0);
    run_line(24'h0A0A0A, 24'h0A0A0A, 16, 1, 0, 8, -1, 5'd0, 8'd0);

    idle(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending pixels expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
